// File: rtl/fp_pe_pkg.sv
// ---------------------------------------------------------------------------
// fp_pe_pkg
// Shared definitions for the multi-precision dot-product PE issue side:
// precision mode encodings, per-mode element width, lane count, exponent
// field position, packed vector width and packer state encoding.
// ---------------------------------------------------------------------------
package fp_pe_pkg;

    localparam int VEC_W     = 160;
    localparam int LANES_MAX = 10;

    localparam logic [2:0] MODE_FP16 = 3'b000;
    localparam logic [2:0] MODE_FP32 = 3'b001;
    localparam logic [2:0] MODE_FP64 = 3'b010;
    localparam logic [2:0] MODE_BF16 = 3'b011;
    localparam logic [2:0] MODE_TF32 = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } pk_state_e;

    function automatic logic mode_legal(input logic [2:0] mode);
        return (mode <= MODE_TF32);
    endfunction

    // Significant bits per element; 0 for illegal modes.
    function automatic logic [6:0] mode_width(input logic [2:0] mode);
        case (mode)
            MODE_FP16: return 7'd16;
            MODE_FP32: return 7'd32;
            MODE_FP64: return 7'd64;
            MODE_BF16: return 7'd16;
            MODE_TF32: return 7'd19;
            default:   return 7'd0;
        endcase
    endfunction

    // Lanes per vector; 0 for illegal modes.
    function automatic logic [3:0] mode_lanes(input logic [2:0] mode);
        case (mode)
            MODE_FP16: return 4'd10;
            MODE_FP32: return 4'd5;
            MODE_FP64: return 4'd1;
            MODE_BF16: return 4'd10;
            MODE_TF32: return 4'd1;
            default:   return 4'd0;
        endcase
    endfunction

    // Exponent field LSB (equals mantissa width).
    function automatic logic [5:0] mode_exp_lsb(input logic [2:0] mode);
        case (mode)
            MODE_FP16: return 6'd10;
            MODE_FP32: return 6'd23;
            MODE_FP64: return 6'd52;
            MODE_BF16: return 6'd7;
            MODE_TF32: return 6'd10;
            default:   return 6'd0;
        endcase
    endfunction

    // Exponent field MSB (sign bit sits just above it).
    function automatic logic [5:0] mode_exp_msb(input logic [2:0] mode);
        case (mode)
            MODE_FP16: return 6'd14;
            MODE_FP32: return 6'd30;
            MODE_FP64: return 6'd62;
            MODE_BF16: return 6'd14;
            MODE_TF32: return 6'd17;
            default:   return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/fp_lane_screen.sv
// ---------------------------------------------------------------------------
// fp_lane_screen
// Combinational per-element screen. Truncates the element to the mode's
// significant width and, when FP_PACKER_DENORM_FLUSH_EN is defined, clears
// the mantissa of any element whose exponent field is zero (sign kept).
// Without the macro the element passes bit-exact (after width truncation).
//
// Ports:
//   mode     in  3   precision mode of the element
//   elem_in  in  64  raw LSB-aligned element
//   elem_out out 64  screened element, bits above the mode width zero
// ---------------------------------------------------------------------------
module fp_lane_screen
    import fp_pe_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [63:0] elem_in,
    output logic [63:0] elem_out
);

    logic [63:0] wmask;
    logic [63:0] masked;

    // Shift by 64 yields zero, so the FP64 mask becomes all ones.
    assign wmask  = (64'd1 << mode_width(mode)) - 64'd1;
    assign masked = elem_in & wmask;

`ifdef FP_PACKER_DENORM_FLUSH_EN
    logic [63:0] mant_mask;
    logic [63:0] exp_mask;

    assign mant_mask = (64'd1 << mode_exp_lsb(mode)) - 64'd1;
    assign exp_mask  = ((64'd1 << (mode_exp_msb(mode) + 6'd1)) - 64'd1) & ~mant_mask;

    always_comb begin
        elem_out = masked;
        if ((masked & exp_mask) == 64'd0) begin
            elem_out = masked & ~mant_mask;
        end
    end
`else
    assign elem_out = masked;
`endif

endmodule

// File: rtl/fp_operand_packer.sv
// ---------------------------------------------------------------------------
// fp_operand_packer
// Packs a stream of scalar A/B operand pairs lane-by-lane into 160-bit PE
// vector words for the selected precision mode, zero-pads unfilled lanes and
// presents the vector with a valid/ready handshake.
// Optional feature: FP_PACKER_DENORM_FLUSH_EN (flush zero-exponent elements).
//
// Ports:
//   clk        in   1    system clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    element pair valid
//   in_ready   out  1    packer accepts an element this cycle
//   in_a/in_b  in   64   LSB-aligned A/B element
//   in_mode    in   3    precision mode, sampled on the first element only
//   in_last    in   1    close the vector after this element
//   out_valid  out  1    packed vector available
//   out_ready  in   1    PE consumes the vector
//   out_a/out_b out 160  packed A/B vectors
//   out_mode   out  3    mode of the packed vector
//   out_lanes  out  4    lanes filled (1..10)
//   err        out  1    one-cycle pulse: illegal-mode element dropped
// ---------------------------------------------------------------------------
module fp_operand_packer
    import fp_pe_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_a,
    input  logic [63:0]  in_b,
    input  logic [2:0]   in_mode,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [159:0] out_a,
    output logic [159:0] out_b,
    output logic [2:0]   out_mode,
    output logic [3:0]   out_lanes,
    output logic         err
);

    pk_state_e    state_q, state_d;
    logic [3:0]   cnt_q;
    logic [2:0]   mode_q;
    logic [159:0] buf_a_q, buf_b_q;
    logic         err_q;

    logic [2:0]   cur_mode;
    logic [3:0]   cur_lanes;
    logic [6:0]   cur_w;
    logic         take;
    logic         wr;
    logic         clr;
    logic         drop;
    logic [7:0]   sh;
    logic [63:0]  scr_a, scr_b;
    logic [159:0] lane_a, lane_b;

    // The first element's mode governs the whole vector.
    assign cur_mode  = (state_q == ST_IDLE) ? in_mode : mode_q;
    assign cur_lanes = mode_lanes(cur_mode);
    assign cur_w     = mode_width(cur_mode);

    fp_lane_screen u_screen_a (.mode(cur_mode), .elem_in(in_a), .elem_out(scr_a));
    fp_lane_screen u_screen_b (.mode(cur_mode), .elem_in(in_b), .elem_out(scr_b));

    // Multi-lane: lane k lands at [159-k*W -: W]; single-lane sits at the LSBs.
    always_comb begin
        sh = 8'd0;
        if (cur_lanes != 4'd1) begin
            sh = 8'(VEC_W) - (8'(cnt_q + 4'd1) * 8'(cur_w));
        end
        lane_a = {96'd0, scr_a} << sh;
        lane_b = {96'd0, scr_b} << sh;
    end

    always_comb begin
        state_d = state_q;
        wr      = 1'b0;
        clr     = 1'b0;
        drop    = 1'b0;
        take    = in_valid && (state_q != ST_HOLD);
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    if (!mode_legal(in_mode)) begin
                        drop = 1'b1;
                    end else begin
                        wr = 1'b1;
                        state_d = (cur_lanes == 4'd1 || in_last) ? ST_HOLD : ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (take) begin
                    wr = 1'b1;
                    if ((cnt_q + 4'd1) == cur_lanes || in_last) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Vector buffer: lanes OR into a zeroed buffer, cleared on hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 4'd0;
            mode_q  <= 3'b000;
            buf_a_q <= '0;
            buf_b_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= drop;
            if (clr) begin
                cnt_q   <= 4'd0;
                mode_q  <= 3'b000;
                buf_a_q <= '0;
                buf_b_q <= '0;
            end else if (wr) begin
                cnt_q   <= cnt_q + 4'd1;
                buf_a_q <= buf_a_q | lane_a;
                buf_b_q <= buf_b_q | lane_b;
                if (state_q == ST_IDLE) begin
                    mode_q <= in_mode;
                end
            end
        end
    end

    assign in_ready  = (state_q != ST_HOLD);
    assign out_valid = (state_q == ST_HOLD);
    assign out_a     = buf_a_q;
    assign out_b     = buf_b_q;
    assign out_mode  = mode_q;
    assign out_lanes = cnt_q;
    assign err       = err_q;

endmodule

// File: doc/fp_operand_packer.md
# fp_operand_packer

Issue-side producer for the multi-precision dot-product PE. Accepts a stream of scalar operand pairs (one A element, one B element per beat), packs them lane-by-lane into the PE's 160-bit A/B vector words for the selected precision mode, zero-pads unfilled lanes, and presents a complete vector with a valid/ready handshake. It sits directly in front of the PE's A/B/mode inputs.

## Interface
- LANES_MAX, 10: maximum lane count (FP16/BF16).
- VEC_W, 160: packed vector width.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input element pair valid.
- in_ready  out  1  packer can accept an element this cycle.
- in_a  in  64  A element, LSB-aligned (16/19/32/64 significant bits per mode).
- in_b  in  64  B element, LSB-aligned.
- in_mode  in  3  precision mode; sampled only on the first element of a vector.
- in_last  in  1  close vector after this element (partial fill).
- out_valid  out  1  packed vector available.
- out_ready  in  1  PE consumes vector.
- out_a  out  160  packed A vector.
- out_b  out  160  packed B vector.
- out_mode  out  3  mode of the packed vector.
- out_lanes  out  4  number of lanes actually filled (1..10).
- err  out  1  one-cycle pulse: element with illegal mode dropped.

## Operation
- Mode encodings / lane geometry: 000 FP16 10×16b; 001 FP32 5×32b; 010 FP64 1×64b; 011 BF16 10×16b; 100 TF32 1×19b; 101–111 illegal.
- Multi-lane modes: k-th accepted element (k from 0) written to bits [159−k·W −: W] (first element most significant). Single-lane modes: element written to bits [W−1:0], upper bits zero.
- Element taken from in_a[W−1:0]/in_b[W−1:0]; upper input bits ignored.
- Unfilled lanes are zero (contribute 0 to the PE sum).
- States: IDLE (empty), FILL (≥1 lane held), HOLD (out_valid=1).
- IDLE: accept → capture in_mode, write lane 0; if lane count N=1 or in_last → HOLD, else FILL.
- FILL: accept → write lane k; k+1==N or in_last → HOLD. in_mode ignored.
- HOLD: out_valid=1, in_ready=0; out_valid&&out_ready → clear buffer, IDLE.
- in_ready = (state != HOLD).
- Illegal in_mode on a first element: element dropped, err pulses, stays IDLE.
- Vector buffer cleared to zero on entry to IDLE, so no stale lanes leak.

## Timing
- Reset (async assert, sync-released by system): state IDLE, lane counter 0, out_valid 0, out_a/out_b 0, out_mode 000, out_lanes 0, err 0; in_ready 1.
- Latency: out_valid rises the cycle after the closing element is accepted.
- Full-vector throughput: N accept cycles + 1 hand-off cycle; no accept in the hand-off cycle.
- out_a/out_b/out_mode/out_lanes stable while out_valid=1 and out_ready=0.
- in_last on element N−1 and full count coincide: one vector, no empty follow-up.
- Reset mid-FILL or mid-HOLD: partial vector discarded, no out_valid.

## Configuration
- FP_PACKER_DENORM_FLUSH_EN defined: any element whose exponent field is zero (FP16 bits 14:10, BF16 14:7, FP32 30:23, FP64 62:52, TF32 17:10) has its mantissa cleared before packing (signed zero kept).
- Undefined: elements packed bit-exact.

## Structure
- Shared package fp_pe_pkg: mode encodings, per-mode element width, lane count, exponent field position, VEC_W.
- One sub-module: fp_lane_screen (combinational per-mode denorm flush, pass-through when macro undefined).

## Test plan
- FP32, 5 beats A=43280000,4335ae14,40751eb8,35ae7ba9,00000000 / B=3f800000,420551ec,42899eb8,4b895440,461c4000 → out_a/out_b equal concatenations in order, out_lanes=5, out_valid one cycle after beat 5.
- FP64 single beat A=406514467381D7DC, B=4066BA2E87D2C7B9 → out_a=160'h406514467381D7DC, out_b likewise, out_lanes=1.
- BF16 8 beats (A=40A0..C1F8), in_last on beat 8 → out_a[31:0]=0, out_lanes=8; in_mode changed to 001 on beat 3 ignored.
- TF32 A=19'b0100000001100000000 → out_a={141'b0, that value}; out_ready held low 5 cycles → outputs stable, in_ready=0.
- in_mode=110 first beat → err pulse, in_ready stays 1, no out_valid; rst_n low during FILL after 3 FP16 beats → all outputs reset, next vector starts at lane 0.
- With FP_PACKER_DENORM_FLUSH_EN: FP16 A=0x8001 → lane = 0x8000; without macro lane = 0x8001.
